// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM state type and stream-format constants for the boot loader.
package imem_loader_pkg;
   typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
   localparam int LEN_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles 4 accepted bytes little-endian into a word.
// Ports: i_clk/i_rst clock and sync reset, i_clr restarts the word, i_en accepts i_byte;
// o_word is the assembled word, valid (combinationally) with o_word_valid on the 4th byte.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clr,
   input  logic        i_en,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic        o_word_valid
);
   logic [1:0]  r_cnt;
   logic [23:0] r_sr;
   // the 4th byte completes the word without waiting for a shift
   assign o_word       = {i_byte, r_sr};
   assign o_word_valid = i_en && (r_cnt == 2'(BYTES_PER_WORD - 1));
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
         r_sr  <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 2'd1;
         r_sr  <= {i_byte, r_sr[23:8]};
      end
   end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed, XOR-checksummed byte stream into instruction memory.
// Ports: i_start begins a load; i_byte_valid/i_byte_data/o_byte_ready byte handshake;
// o_we/o_waddr/o_wdata memory write port; o_busy/o_done/o_err status; o_cpu_rst_hold core reset.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_byte_valid,
   input  logic [7:0]        i_byte_data,
   output logic              o_byte_ready,
   output logic              o_we,
   output logic [ADDR_W-1:0] o_waddr,
   output logic [31:0]       o_wdata,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic              o_cpu_rst_hold
);
   state_t            r_state;
   logic              r_ready, r_we, r_busy, r_done, r_err, r_hold;
   logic [ADDR_W-1:0] r_waddr;
   logic [31:0]       r_wdata;
   logic [ADDR_W:0]   r_wcnt;
   logic [15:0]       r_len;
   logic [7:0]        r_csum;
   logic              w_acc, w_restart, w_word_valid;
   logic [15:0]       w_len;
   logic [31:0]       w_word;
   assign w_acc     = i_byte_valid && r_ready;
   assign w_restart = i_start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
   assign w_len     = {i_byte_data, r_len[7:0]};
   byte_packer u_packer (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_clr       (w_restart),
      .i_en        (w_acc && r_state == S_DATA),
      .i_byte      (i_byte_data),
      .o_word      (w_word),
      .o_word_valid(w_word_valid)
   );
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_ready <= 1'b0;
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_hold  <= 1'b1;
         r_wcnt  <= '0;
         r_len   <= '0;
         r_csum  <= '0;
      end else begin
         r_we <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_ERR: if (w_restart) begin
               r_state <= S_LEN0;
               r_ready <= 1'b1;
               r_busy  <= 1'b1;
               r_done  <= 1'b0;
               r_err   <= 1'b0;
               r_hold  <= 1'b1;
               r_wcnt  <= '0;
               r_csum  <= '0;
            end
            S_LEN0: if (w_acc) begin
               r_len[7:0] <= i_byte_data;
               r_state    <= S_LEN1;
            end
            S_LEN1: if (w_acc) begin
               r_len[15:8] <= i_byte_data;
               if (w_len > 16'(DEPTH)) begin
                  r_state <= S_ERR;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b0;
                  r_err   <= 1'b1;
               end else
                  r_state <= (w_len == '0) ? S_CSUM : S_DATA;
            end
            S_DATA: if (w_acc) begin
               r_csum <= r_csum ^ i_byte_data;
               if (w_word_valid) begin
                  r_we    <= 1'b1;
                  r_wdata <= w_word;
                  r_waddr <= r_wcnt[ADDR_W-1:0];
                  r_wcnt  <= r_wcnt + (ADDR_W+1)'(1);
                  // counter is one wider than waddr so N = DEPTH still terminates
                  if (16'(r_wcnt) + 16'd1 == r_len) r_state <= S_CSUM;
               end
            end
            S_CSUM: if (w_acc) begin
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
               if (i_byte_data == r_csum) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_hold  <= 1'b0;
               end else begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
   assign o_byte_ready   = r_ready;
   assign o_we           = r_we;
   assign o_waddr        = r_waddr;
   assign o_wdata        = r_wdata;
   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_err          = r_err;
   assign o_cpu_rst_hold = r_hold;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
module tb_imem_loader;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = '0;
   logic        byte_ready, we, busy, done, err, hold;
   logic [7:0]  waddr;
   logic [31:0] wdata;
   int          total = 0;
   int          bad = 0;
   int          nwr = 0;
   int          base;
   logic [7:0]  last_addr = '0;
   logic [31:0] last_data = '0;
   logic [31:0] mem [256];
   logic [7:0]  q [$];
   logic [7:0]  cs;

   imem_loader dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_byte_valid(byte_valid),
      .i_byte_data(byte_data), .o_byte_ready(byte_ready), .o_we(we), .o_waddr(waddr),
      .o_wdata(wdata), .o_busy(busy), .o_done(done), .o_err(err), .o_cpu_rst_hold(hold)
   );

   always #5 clk = ~clk;

   // write monitor samples 2 time units after each rising edge
   always @(posedge clk) begin
      #2;
      if (we) begin
         mem[waddr] = wdata;
         last_addr  = waddr;
         last_data  = wdata;
         nwr        = nwr + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // all drive tasks start and end on a falling edge
   task automatic put(input logic [7:0] b, input int gap);
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) q.push_back(w[8*k +: 8]);
   endtask

   task automatic send_q(input int maxgap);
      while (q.size() > 0) put(q.pop_front(), (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
   endtask

   task automatic load_small(input logic [7:0] csum);
      q = {8'h02, 8'h00};
      push_word(32'h00000513);
      push_word(32'h00100593);
      q.push_back(csum);
      send_q(0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", 32'(byte_ready), 0);
      chk("rst_we", 32'(we), 0);
      chk("rst_waddr", 32'(waddr), 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_hold", 32'(hold), 1);

      // good 2-word image, checksum 13^05^93^05^10 = 0x90
      pulse_start();
      chk("t1_busy", 32'(busy), 1);
      chk("t1_ready", 32'(byte_ready), 1);
      put(8'h02, 0); put(8'h00, 0);
      put(8'h13, 0); put(8'h05, 0); put(8'h00, 0); put(8'h00, 0);
      chk("t1_we0", 32'(we), 1);
      chk("t1_waddr0", 32'(waddr), 0);
      chk("t1_wdata0", wdata, 32'h00000513);
      put(8'h93, 0);
      chk("t1_we_pulse", 32'(we), 0);
      chk("t1_wdata_hold", wdata, 32'h00000513);
      put(8'h05, 0); put(8'h10, 0); put(8'h00, 0);
      chk("t1_we1", 32'(we), 1);
      chk("t1_waddr1", 32'(waddr), 1);
      chk("t1_wdata1", wdata, 32'h00100593);
      chk("t1_busy_csum", 32'(busy), 1);
      put(8'h90, 0);
      chk("t1_done", 32'(done), 1);
      chk("t1_hold", 32'(hold), 0);
      chk("t1_busy_end", 32'(busy), 0);
      chk("t1_ready_end", 32'(byte_ready), 0);
      chk("t1_nwr", nwr, 2);

      // same image, wrong checksum
      pulse_start();
      chk("t2_done_clr", 32'(done), 0);
      chk("t2_hold", 32'(hold), 1);
      base = nwr;
      q = {8'h02, 8'h00};
      push_word(32'h00000513);
      push_word(32'h00100593);
      q.push_back(8'h91);
      send_q(0);
      chk("t2_nwr", nwr - base, 2);
      chk("t2_err", 32'(err), 1);
      chk("t2_done", 32'(done), 0);
      chk("t2_hold_err", 32'(hold), 1);

      // length 257 exceeds depth
      pulse_start();
      chk("t3_err_clr", 32'(err), 0);
      base = nwr;
      put(8'h01, 0); put(8'h01, 0);
      chk("t3_err", 32'(err), 1);
      chk("t3_busy", 32'(busy), 0);
      chk("t3_ready", 32'(byte_ready), 0);
      put(8'h55, 0); put(8'h55, 0); put(8'h55, 0); put(8'h55, 0);
      chk("t3_nwr", nwr - base, 0);
      chk("t3_err_sticky", 32'(err), 1);

      // empty image
      pulse_start();
      base = nwr;
      put(8'h00, 0); put(8'h00, 0);
      chk("t4_busy", 32'(busy), 1);
      put(8'h00, 0);
      chk("t4_done", 32'(done), 1);
      chk("t4_hold", 32'(hold), 0);
      chk("t4_nwr", nwr - base, 0);

      // full 256-word image, word i = {3C, i^5A, ~i, i}
      pulse_start();
      base = nwr;
      cs = '0;
      q = {8'h00, 8'h01};
      for (int i = 0; i < 256; i++) begin
         push_word({8'h3C, 8'(i) ^ 8'h5A, ~8'(i), 8'(i)});
         cs = cs ^ 8'h3C ^ (8'(i) ^ 8'h5A) ^ ~8'(i) ^ 8'(i);
      end
      q.push_back(cs);
      send_q(0);
      chk("t5_nwr", nwr - base, 256);
      chk("t5_last_addr", 32'(last_addr), 255);
      chk("t5_last_data", last_data, 32'h3CA500FF);
      chk("t5_mid", mem[128], 32'h3CDA7F80);
      chk("t5_first", mem[0], 32'h3C5AFF00);
      chk("t5_done", 32'(done), 1);

      // 4-word image with random gaps and an ignored start mid-DATA, csum 0xBA
      pulse_start();
      base = nwr;
      q = {8'h04, 8'h00};
      push_word(32'h00000513);
      push_word(32'h00100593);
      send_q(5);
      pulse_start();
      chk("t6_busy_after_start", 32'(busy), 1);
      push_word(32'hDEADBEEF);
      push_word(32'h12345678);
      q.push_back(8'hBA);
      send_q(5);
      chk("t6_nwr", nwr - base, 4);
      chk("t6_m0", mem[0], 32'h00000513);
      chk("t6_m1", mem[1], 32'h00100593);
      chk("t6_m2", mem[2], 32'hDEADBEEF);
      chk("t6_m3", mem[3], 32'h12345678);
      chk("t6_last_addr", 32'(last_addr), 3);
      chk("t6_done", 32'(done), 1);

      // reset on the edge that accepts word 1's last byte
      pulse_start();
      base = nwr;
      put(8'h02, 0); put(8'h00, 0);
      put(8'hAA, 0); put(8'hBB, 0); put(8'hCC, 0); put(8'hDD, 0);
      put(8'h11, 0); put(8'h22, 0); put(8'h33, 0);
      byte_valid = 1'b1;
      byte_data  = 8'h44;
      rst        = 1'b1;
      @(negedge clk);
      byte_valid = 1'b0;
      rst        = 1'b0;
      chk("t7_we", 32'(we), 0);
      chk("t7_busy", 32'(busy), 0);
      chk("t7_hold", 32'(hold), 1);
      chk("t7_ready", 32'(byte_ready), 0);
      repeat (3) @(negedge clk);
      chk("t7_nwr", nwr - base, 1);
      chk("t7_m0", mem[0], 32'hDDCCBBAA);
      pulse_start();
      base = nwr;
      load_small(8'h90);
      chk("t7_reload_nwr", nwr - base, 2);
      chk("t7_reload_m0", mem[0], 32'h00000513);
      chk("t7_reload_last", last_data, 32'h00100593);
      chk("t7_reload_done", 32'(done), 1);
      chk("t7_reload_hold", 32'(hold), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
